pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard / stall controller for a 5-stage in-order pipeline.
// Resolves load-use hazards, EX-stage redirects and data-memory wait states,
// and halts with a sticky timeout flag if memory never answers.
// Optional feature: define PIPE_CTRL_STATS_EN to add the stall_cnt output.
//
// Memory handshake: mem_req marks a data-memory access by the instruction in
// MEM; the access completes in the cycle where mem_ack=1. Until then the
// whole pipeline is frozen. mem_ack in the request cycle is a zero-wait access.
module pipeline_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       pipe_stall,
    output logic [1:0] state,
`ifdef PIPE_CTRL_STATS_EN
    output logic [15:0] stall_cnt,
`endif
    output logic       timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t     state_q, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_q, timeout_nxt;
    logic       frozen;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign state   = state_q;
    assign timeout = timeout_q;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Next-state logic and prioritised control outputs (freeze > redirect > load-use).
    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout_q;
        frozen       = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_stall   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    frozen       = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == MAX_W) begin
                    frozen      = 1'b1;
                    state_nxt   = HALT;
                    timeout_nxt = 1'b1;
                end else begin
                    frozen       = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            HALT: begin
                frozen = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!rst_n) begin
            // Reset drives both pipeline registers to bubbles and holds the PC.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_stall = 1'b0;
        end else if (frozen) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized checks of pipeline_ctrl against
// a rule-level reference model. Built with MAX_WAIT=4 so timeouts are reachable.
module tb_pipeline_ctrl;

    localparam int MW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_redirect, mem_req, mem_ack;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall, timeout;
    logic [1:0] state;
`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    pipeline_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_stall(pipe_stall), .state(state),
`ifdef PIPE_CTRL_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .timeout(timeout)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int failures = 0;

    // Model: mode 0 running, 1 waiting on memory, 2 halted.
    int  m_mode = 0;
    int  m_waited = 0;   // wait cycles already spent, including the request cycle
    bit  m_timeout = 0;
    int  m_stalls = 0;
    logic [4:0] exp_q[$];  // expected {pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall}

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_ctrl();
        bit frozen, hazard;
        frozen = (m_mode == 2) || (m_mode == 1 && !mem_ack) ||
                 (m_mode == 0 && mem_req && !mem_ack);
        hazard = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (!rst_n)      return 5'b00110;
        if (frozen)      return 5'b00001;
        if (ex_redirect) return 5'b11110;
        if (hazard)      return 5'b00010;
        return 5'b11000;
    endfunction

    // Advance the model across one rising edge using the inputs held this cycle.
    task automatic model_edge(input logic [4:0] ctrl);
        if (!ctrl[4]) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
        case (m_mode)
            0: if (mem_req && !mem_ack) begin m_mode = 1; m_waited = 1; end
            1: begin
                if (mem_ack) m_mode = 0;
                else if (m_waited >= MW) begin m_mode = 2; m_timeout = 1; end
                else m_waited++;
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_timeout = 0; m_stalls = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [4:0] exp;
        exp = exp_q.pop_front();
        chk({tag, ".ctrl"}, {11'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_stall},
            {11'd0, exp});
        chk({tag, ".state"}, {14'd0, state}, 16'(m_mode));
        chk({tag, ".timeout"}, {15'd0, timeout}, {15'd0, m_timeout});
`ifdef PIPE_CTRL_STATS_EN
        chk({tag, ".stall_cnt"}, stall_cnt, 16'(m_stalls));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic mr, input logic rdr, input logic rq, input logic ak);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_redirect = rdr; mem_req = rq; mem_ack = ak;
    endtask

    // One clock cycle: inputs already applied, check mid-cycle, then take the edge.
    task automatic step(input string tag);
        logic [4:0] e;
        #1;
        e = model_ctrl();
        exp_q.push_back(e);
        check_outputs(tag);
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    // Asynchronous reset pulse started mid-cycle, released at a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back(5'b00110);
        check_outputs({tag, ".async"});
        @(posedge clk); #1;
        exp_q.push_back(5'b00110);
        check_outputs({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset("reset");

        // idle
        step("idle");
        // load-use on rs2, then with ex_rd = x0 (no hazard)
        set_in(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); step("load_use");
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("load_use_x0");
        set_in(5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); step("no_memread");
        // redirect together with a load-use match
        set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); step("redirect_hazard");
        // zero-wait access
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step("zero_wait");
        // 3-cycle memory wait then ack; redirect applies on the ack cycle
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("mem_wait");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); step("mem_ack");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("after_ack");
        // timeout: 5 freeze cycles then HALT, mem_ack ignored in HALT
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("to_wait");
        step("halted");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); step("halt_ack");
        do_reset("reset_halt");
        // ack exactly at the last allowed wait cycle
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("edge_wait");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step("edge_ack");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("edge_after");
        // reset in the middle of a wait
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pre_rst"); step("pre_rst");
        do_reset("reset_mid_wait");
        // statistics pattern: 2 load-use stalls + 3-cycle wait
        set_in(5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); step("stat_lu");
        set_in(5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); step("stat_lu");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("stat_wait");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step("stat_ack");
`ifdef PIPE_CTRL_STATS_EN
        #1 chk("stat_total", stall_cnt, 16'd5);
`endif

        // randomized traffic with small register indices to provoke matches
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_reset");
            end else begin
                set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 3) == 0));
                step("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout_limit simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
